// File: rtl/syzygy_dac_fm_demod_pkg.sv
// Shared constants and types for the FM demodulator.
//   PHASE_W   : phase word / carrier increment width
//   DEV_W     : frequency-deviation control width
//   DIV_W     : divisor width (freq_dev >> 1)
//   AUDIO_W   : offset-binary audio width
//   AUDIO_MID : silence code
//   Q_MIN/MAX : signed quotient clamp range before the offset is added
package syzygy_dac_fm_demod_pkg;
  localparam int PHASE_W = 28;
  localparam int DEV_W   = 16;
  localparam int DIV_W   = DEV_W - 1;
  localparam int AUDIO_W = 12;

  localparam logic [AUDIO_W-1:0] AUDIO_MID = 12'h7FF;
  localparam int Q_MIN = -2047;
  localparam int Q_MAX = 2048;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIFF,
    ST_DIV,
    ST_OUT
  } state_t;
endpackage

// File: rtl/syzygy_dac_fm_demod_if.sv
// Sample/result bus of the FM demodulator.
//   master : phase source / audio sink (drives freq_dev, carrier_inc,
//            phase_in, in_valid; observes in_ready, audio, audio_valid, div_err)
//   slave  : the demodulator
interface syzygy_dac_fm_demod_if;
  import syzygy_dac_fm_demod_pkg::*;

  logic [DEV_W-1:0]   freq_dev;
  logic [PHASE_W-1:0] carrier_inc;
  logic [PHASE_W-1:0] phase_in;
  logic               in_valid;
  logic               in_ready;
  logic [AUDIO_W-1:0] audio;
  logic               audio_valid;
  logic               div_err;

  modport master (
    output freq_dev, carrier_inc, phase_in, in_valid,
    input  in_ready, audio, audio_valid, div_err
  );

  modport slave (
    input  freq_dev, carrier_inc, phase_in, in_valid,
    output in_ready, audio, audio_valid, div_err
  );
endinterface

// File: rtl/syzygy_serial_div.sv
// Unsigned restoring divider, one quotient bit per clock.
//   clk, reset_n : clock, async active-low reset (control only)
//   abort        : sync flush, drops any division in progress
//   start        : load dividend/divisor (one-cycle pulse while idle)
//   dividend     : DVD_W-bit unsigned numerator
//   divisor      : DVS_W-bit unsigned denominator, must be non-zero
//   busy         : iterations in progress
//   done         : high during the final iteration; quotient is valid
//                  from the following edge until the next start
//   quotient     : DVD_W-bit truncated quotient
module syzygy_serial_div #(
  parameter int DVD_W = 28,
  parameter int DVS_W = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             abort,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient
);
  localparam int CNT_W = $clog2(DVD_W);

  logic [CNT_W-1:0] cnt;
  logic [DVS_W-1:0] rem;
  logic [DVS_W-1:0] dvs;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [DVD_W-1:0] work;
  logic [DVS_W:0]   trial;
  logic             fits;

  // Remainder is always below the divisor, so the shifted trial needs
  // just one extra bit.
  always_comb begin
    trial = {rem, work[DVD_W-1]};
    fits  = (trial >= {1'b0, dvs});
  end

  assign done     = busy && (cnt == '0);
  assign quotient = work;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (abort) begin
      busy <= 1'b0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= CNT_W'(DVD_W - 1);
    end else if (busy) begin
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rem  <= '0;
      work <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem  <= fits ? DVS_W'(trial - {1'b0, dvs}) : trial[DVS_W-1:0];
      work <= {work[DVD_W-2:0], fits};
    end
  end
endmodule

// File: rtl/syzygy_dac_fm_demod.sv
// FM demodulator: phase differentiator, carrier removal, serial divide by
// the programmed deviation, offset-binary audio out.
//   clk     : system clock (posedge)
//   reset_n : async active-low reset
//   dis     : sync disable; aborts, unprimes and forces silence
//   bus     : slave side of the sample/result interface
//             (freq_dev, carrier_inc, phase_in, in_valid -> in_ready,
//              audio, audio_valid, div_err)
// Timing: accept edge 0, difference edge 1, divide edges 2..29, audio
// strobe edge 30. A zero divisor skips the divide and strobes div_err.
module syzygy_dac_fm_demod
  import syzygy_dac_fm_demod_pkg::*;
(
  input logic                   clk,
  input logic                   reset_n,
  input logic                   dis,
  syzygy_dac_fm_demod_if.slave  bus
);
  state_t             state;
  logic               primed;
  logic               live;
  logic [PHASE_W-1:0] phase_prev;

  logic [PHASE_W-1:0] phase_p0;
  logic [PHASE_W-1:0] inc_p0;
  logic [DEV_W-1:0]   dvsr_p0;

  logic signed [PHASE_W-1:0] delta_p1;
  logic [PHASE_W-1:0]        mag_p1;
  logic                      neg_p1;
  logic                      zero_p1;

  logic               accept;
  logic               div_start;
  logic               div_busy;
  logic               div_done;
  logic [PHASE_W-1:0] div_quo;

  logic [AUDIO_W-1:0] audio_q;
  logic               audio_valid_q;
  logic               div_err_q;

  // Clamp the signed quotient to [Q_MIN, Q_MAX] and add the mid-scale offset.
  function automatic logic [AUDIO_W-1:0] sat_audio(input logic neg,
                                                   input logic [PHASE_W-1:0] mag);
    logic [PHASE_W-1:0] lim;
    lim = neg ? PHASE_W'(-Q_MIN) : PHASE_W'(Q_MAX);
    if (mag < lim) lim = mag;
    return neg ? AUDIO_MID - AUDIO_W'(lim) : AUDIO_MID + AUDIO_W'(lim);
  endfunction

  // live keeps in_ready low while reset is held, without reset_n
  // appearing in combinational logic.
  assign bus.in_ready    = live && (state == ST_IDLE) && !dis && !div_busy;
  assign bus.audio       = audio_q;
  assign bus.audio_valid = audio_valid_q;
  assign bus.div_err     = div_err_q;

  assign accept = bus.in_valid && bus.in_ready;

  // Modular subtraction handles phase wrap across 2^PHASE_W for free.
  always_comb begin
    delta_p1  = $signed(phase_p0 - phase_prev - inc_p0);
    mag_p1    = delta_p1[PHASE_W-1] ? $unsigned(-delta_p1) : $unsigned(delta_p1);
    div_start = (state == ST_DIFF) && !dis && (dvsr_p0 != '0);
  end

  syzygy_serial_div #(
    .DVD_W (PHASE_W),
    .DVS_W (DIV_W)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .abort    (dis),
    .start    (div_start),
    .dividend (mag_p1),
    .divisor  (dvsr_p0[DIV_W-1:0]),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      primed        <= 1'b0;
      live          <= 1'b0;
      phase_prev    <= '0;
      audio_q       <= AUDIO_MID;
      audio_valid_q <= 1'b0;
      div_err_q     <= 1'b0;
    end else begin
      live          <= 1'b1;
      audio_valid_q <= 1'b0;
      div_err_q     <= 1'b0;
      if (dis) begin
        state   <= ST_IDLE;
        primed  <= 1'b0;
        audio_q <= AUDIO_MID;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              if (primed) begin
                state <= ST_DIFF;
              end else begin
                primed     <= 1'b1;
                phase_prev <= bus.phase_in;
              end
            end
          end
          ST_DIFF: begin
            phase_prev <= phase_p0;
            state      <= (dvsr_p0 == '0) ? ST_OUT : ST_DIV;
          end
          ST_DIV: begin
            if (div_done) state <= ST_OUT;
          end
          ST_OUT: begin
            audio_valid_q <= 1'b1;
            div_err_q     <= zero_p1;
            audio_q       <= zero_p1 ? AUDIO_MID : sat_audio(neg_p1, div_quo);
            state         <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Stage p0: operands captured at accept
  always_ff @(posedge clk) begin
    if (accept) begin
      phase_p0 <= bus.phase_in;
      inc_p0   <= bus.carrier_inc;
      dvsr_p0  <= bus.freq_dev >> 1;
    end
  end

  // Stage p1: sign and divisor class captured at the difference step
  always_ff @(posedge clk) begin
    if (state == ST_DIFF) begin
      neg_p1  <= delta_p1[PHASE_W-1];
      zero_p1 <= (dvsr_p0 == '0);
    end
  end
endmodule

// File: tb/tb_syzygy_dac_fm_demod.sv
module tb_syzygy_dac_fm_demod;
  logic clk = 1'b0;
  logic reset_n;
  logic dis;

  syzygy_dac_fm_demod_if bus ();

  syzygy_dac_fm_demod dut (
    .clk     (clk),
    .reset_n (reset_n),
    .dis     (dis),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] audio;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc   = 0;
  logic        m_primed = 1'b0;
  logic [27:0] m_prev   = '0;
  logic [11:0] m_audio  = 12'h7FF;

  logic [27:0] ph_t;
  logic [27:0] inc_t;
  logic [15:0] fd_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: signed deviation modulo 2^28.
  function automatic longint wrap_delta(logic [27:0] ph, logic [27:0] prev, logic [27:0] inc);
    longint u;
    u = (longint'(ph) - longint'(prev) - longint'(inc)) & 64'h0FFF_FFFF;
    if (u >= 64'sd134217728) u = u - 64'sd268435456;
    return u;
  endfunction

  // Reference: truncating signed divide, clamp, offset to 0..4095.
  function automatic logic [11:0] calc_audio(longint delta, longint d);
    longint qv;
    qv = ((delta < 0) ? -delta : delta) / d;
    if (delta < 0) qv = -qv;
    if (qv > 2048)  qv = 2048;
    if (qv < -2047) qv = -2047;
    return 12'(qv + 2047);
  endfunction

  function automatic void model_accept(logic [27:0] ph, logic [15:0] fd, logic [27:0] inc, int acc);
    longint delta;
    longint d;
    if (!m_primed) begin
      m_primed = 1'b1;
      m_prev   = ph;
      return;
    end
    delta  = wrap_delta(ph, m_prev, inc);
    m_prev = ph;
    d      = longint'(fd) / 2;
    if (d == 0) exp_q.push_back('{audio: 12'h7FF, err: 1'b1, acc: acc});
    else        exp_q.push_back('{audio: calc_audio(delta, d), err: 1'b0, acc: acc});
  endfunction

  function automatic void model_flush();
    exp_q.delete();
    m_primed = 1'b0;
    m_audio  = 12'h7FF;
  endfunction

  // Compare process: samples 2 time units after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (bus.audio_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {20'd0, bus.audio}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("audio", bus.audio, e.audio);
          chk("div_err", bus.div_err, e.err);
          if (e.err) chk("zero_latency_bound", (cyc - e.acc) <= 30, 1);
          else       chk("latency", cyc - e.acc, 30);
          m_audio = e.audio;
        end
      end else begin
        chk("div_err_idle", bus.div_err, 0);
        if (exp_q.size() > 0 && (cyc - exp_q[0].acc) > 30) begin
          chk("output_overdue", cyc - exp_q[0].acc, 30);
          void'(exp_q.pop_front());
        end
      end
      chk("audio_hold", bus.audio, m_audio);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input logic [27:0] ph, input logic [15:0] fd, input logic [27:0] inc);
    int n;
    n = 0;
    bus.phase_in    = ph;
    bus.freq_dev    = fd;
    bus.carrier_inc = inc;
    bus.in_valid    = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    if (!bus.in_ready) begin
      bus.in_valid = 1'b0;
      return;
    end
    model_accept(ph, fd, inc, cyc + 1);
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.phase_in    = 28'($urandom);
    bus.freq_dev    = 16'($urandom);
    bus.carrier_inc = 28'($urandom);
  endtask

  task automatic expect_out(input string nm, input logic [11:0] lit, input logic err);
    int n;
    n = 0;
    while (!bus.audio_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_valid"}, bus.audio_valid, 1);
    chk({nm, "_audio"}, bus.audio, lit);
    chk({nm, "_err"}, bus.div_err, err);
    @(negedge clk);
  endtask

  task automatic step(input longint delta, input logic [11:0] lit, input logic err, input string nm);
    ph_t = 28'(longint'(ph_t) + longint'(inc_t) + delta);
    send(ph_t, fd_t, inc_t);
    expect_out(nm, lit, err);
  endtask

  task automatic prime(input logic [27:0] ph);
    ph_t = ph;
    send(ph_t, fd_t, inc_t);
    idle(34);
  endtask

  task automatic dis_pulse();
    dis = 1'b1;
    model_flush();
    #1;
    chk("dis_in_ready", bus.in_ready, 0);
    @(negedge clk);
    dis = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.phase_in    = '0;
    bus.freq_dev    = '0;
    bus.carrier_inc = '0;
    dis             = 1'b0;
    reset_n         = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_audio", bus.audio, 12'h7FF);
    chk("rst_valid", bus.audio_valid, 0);
    chk("rst_err", bus.div_err, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    idle(3);
    reset_n = 1'b1;
    idle(2);

    chk("model_pos", calc_audio(25600, 256), 12'h863);
    chk("model_neg", calc_audio(-25600, 256), 12'h79B);
    chk("model_trunc", calc_audio(-300, 256), 12'h7FE);
    chk("model_clamp", calc_audio(-768000, 256), 12'h000);
    chk("model_wrap", 32'(wrap_delta(28'h0106300, 28'hFFFFF00, 28'h0100000)), 32'd25600);

    fd_t  = 16'h0200;
    inc_t = 28'h0100000;
    prime(28'h0000000);
    step(25600,   12'h863, 1'b0, "basic");
    step(-25600,  12'h79B, 1'b0, "neg");
    step(-300,    12'h7FE, 1'b0, "trunc_neg");
    step(255,     12'h7FF, 1'b0, "trunc_pos");
    step(768000,  12'hFFF, 1'b0, "clamp_hi");
    step(-768000, 12'h000, 1'b0, "clamp_lo");
    step(524288,  12'hFFF, 1'b0, "exact_max");
    step(-524032, 12'h000, 1'b0, "exact_min");

    ph_t = 28'hFFFFF00;
    send(ph_t, fd_t, inc_t);
    idle(34);
    ph_t = 28'h0106300;
    send(ph_t, fd_t, inc_t);
    expect_out("wrap", 12'h863, 1'b0);

    fd_t = 16'h0001;
    step(25600, 12'h7FF, 1'b1, "zero_div");
    fd_t = 16'h0200;
    step(25600, 12'h863, 1'b0, "after_zero");

    ph_t = 28'(ph_t + inc_t + 28'd25600);
    send(ph_t, fd_t, inc_t);
    idle(14);
    dis_pulse();
    idle(40);
    chk("dis_audio", bus.audio, 12'h7FF);
    prime(28'h0123456);
    step(25600, 12'h863, 1'b0, "after_dis");

    ph_t = 28'(ph_t + inc_t + 28'd51200);
    send(ph_t, fd_t, inc_t);
    idle(12);
    reset_n = 1'b0;
    model_flush();
    #1;
    chk("arst_audio", bus.audio, 12'h7FF);
    chk("arst_valid", bus.audio_valid, 0);
    chk("arst_err", bus.div_err, 0);
    chk("arst_in_ready", bus.in_ready, 0);
    idle(2);
    reset_n = 1'b1;
    idle(2);
    prime(28'h0ABCDEF);
    step(-25600, 12'h79B, 1'b0, "after_arst");

    for (int i = 0; i < 300; i++) begin
      int          r;
      longint      delta;
      logic [15:0] fd;
      logic [27:0] inc;
      r   = $urandom_range(0, 9);
      fd  = (r == 0) ? 16'($urandom_range(0, 1)) : 16'($urandom_range(2, 65535));
      inc = 28'($urandom);
      case ($urandom_range(0, 3))
        0:       delta = longint'($urandom_range(0, 2000)) - 1000;
        1:       delta = (longint'($urandom_range(0, 8000)) - 4000) * longint'(fd >> 1);
        2:       delta = longint'($urandom_range(0, 2097152)) - 1048576;
        default: delta = longint'($urandom);
      endcase
      ph_t = 28'(longint'(ph_t) + longint'(inc) + delta);
      send(ph_t, fd, inc);
      r = $urandom_range(0, 29);
      if (r == 0) begin
        idle($urandom_range(0, 34));
        dis_pulse();
      end else if (r == 1) begin
        idle($urandom_range(0, 30));
        reset_n = 1'b0;
        model_flush();
        idle(2);
        reset_n = 1'b1;
      end else begin
        idle($urandom_range(0, 2));
      end
    end

    idle(40);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
